cmd_sequencer: RTL and testbench

Command sequencer inside MazeRunner, sitting between the UART command wrapper (fed by the RemoteComm link) and the navigation/inertial datapath. Decodes each 16-bit remote command, launches the matching operation (calibrate, change heading, move, solve), waits for that operation's completion strobe, then issues one response byte back through the wrapper. Only one command is in flight at a time; a per-command watchdog turns a stuck operation into a negative acknowledge.

---
 rtl/cmd_sequencer_pkg.sv | 27 ++
 rtl/cmd_watchdog.sv | 37 +++
 rtl/cmd_sequencer.sv | 145 ++++++++++++++
 tb/tb_cmd_sequencer.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_sequencer_pkg.sv
// Shared types and constants for the remote command sequencer:
// opcodes, FSM states, acknowledge bytes and watchdog widths.
package cmd_sequencer_pkg;

  typedef enum logic [2:0] {
    CMD_CAL   = 3'b000,
    CMD_HDG   = 3'b001,
    CMD_MV    = 3'b010,
    CMD_SOLVE = 3'b011
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAL,
    ST_HDG,
    ST_MV,
    ST_SOLVE,
    ST_RESP
  } state_e;

  localparam logic [7:0] POS_ACK_DFLT = 8'hA5;
  localparam logic [7:0] NEG_ACK_DFLT = 8'h5A;

  localparam int WD_W_FAST = 14;
  localparam int WD_W_SLOW = 22;

endpackage

// File: rtl/cmd_watchdog.sv
// Per-command watchdog: counts cycles spent in a wait state and flags the
// last cycle before the operation is declared stuck.
module cmd_watchdog
  import cmd_sequencer_pkg::*;
#(
  parameter bit FAST_SIM = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int W = FAST_SIM ? WD_W_FAST : WD_W_SLOW;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  // All-ones means this is the 2^W-th cycle in the wait state.
  assign tc_o = en_i && (cnt_q == {W{1'b1}});

endmodule

// File: rtl/cmd_sequencer.sv
// Decodes remote commands, launches the matching navigation operation,
// waits for its completion strobe and returns one acknowledge byte.
//   state    | meaning
//   IDLE     | waiting for cmd_rdy
//   CAL      | calibration running, waiting for cal_done
//   HDG      | heading change running, waiting for mv_cmplt
//   MV       | move running, waiting for mv_cmplt
//   SOLVE    | solver owns navigation, waiting for sol_cmplt
//   RESP     | resp loaded, send_resp issued on exit
module cmd_sequencer
  import cmd_sequencer_pkg::*;
#(
  parameter bit         FAST_SIM = 1'b1,
  parameter logic [7:0] POS_ACK  = POS_ACK_DFLT,
  parameter logic [7:0] NEG_ACK  = NEG_ACK_DFLT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        cmd_rdy,
  output logic        clr_cmd_rdy,
  output logic [7:0]  resp,
  output logic        send_resp,
  output logic        strt_cal,
  input  logic        cal_done,
  output logic        in_cal,
  output logic        strt_hdng,
  output logic [11:0] dsrd_hdg,
  output logic        strt_mv,
  output logic        stp_lft,
  output logic        stp_rght,
  input  logic        mv_cmplt,
  output logic        cmd_md,
  input  logic        sol_cmplt
);

  state_e      state_q;
  logic        clr_cmd_rdy_q, send_resp_q;
  logic        strt_cal_q, strt_hdng_q, strt_mv_q;
  logic        in_cal_q, stp_lft_q, stp_rght_q, cmd_md_q;
  logic [7:0]  resp_q;
  logic [11:0] dsrd_hdg_q;
  logic        wd_clr, wd_en, wd_tc;
  logic        unused_cmd_bit;

  assign unused_cmd_bit = cmd[12];

  assign wd_clr = (state_q == ST_IDLE);
  assign wd_en  = (state_q == ST_CAL) || (state_q == ST_HDG) || (state_q == ST_MV);

  cmd_watchdog #(.FAST_SIM(FAST_SIM)) u_wd (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (wd_clr),
    .en_i  (wd_en),
    .tc_o  (wd_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      clr_cmd_rdy_q <= 1'b0;
      send_resp_q   <= 1'b0;
      strt_cal_q    <= 1'b0;
      strt_hdng_q   <= 1'b0;
      strt_mv_q     <= 1'b0;
      in_cal_q      <= 1'b0;
      stp_lft_q     <= 1'b0;
      stp_rght_q    <= 1'b0;
      cmd_md_q      <= 1'b1;
      resp_q        <= 8'h00;
      dsrd_hdg_q    <= 12'h000;
    end else begin
      clr_cmd_rdy_q <= 1'b0;
      send_resp_q   <= 1'b0;
      strt_cal_q    <= 1'b0;
      strt_hdng_q   <= 1'b0;
      strt_mv_q     <= 1'b0;
      case (state_q)
        ST_IDLE: if (cmd_rdy) begin
          clr_cmd_rdy_q <= 1'b1;
          case (cmd[15:13])
            CMD_CAL: begin
              strt_cal_q <= 1'b1;
              in_cal_q   <= 1'b1;
              state_q    <= ST_CAL;
            end
            CMD_HDG: begin
              dsrd_hdg_q  <= cmd[11:0];
              strt_hdng_q <= 1'b1;
              state_q     <= ST_HDG;
            end
            CMD_MV: begin
              stp_lft_q  <= cmd[1];
              stp_rght_q <= cmd[0];
              strt_mv_q  <= 1'b1;
              state_q    <= ST_MV;
            end
            CMD_SOLVE: begin
              cmd_md_q <= 1'b0;
              state_q  <= ST_SOLVE;
            end
            default: begin
              resp_q  <= NEG_ACK;
              state_q <= ST_RESP;
            end
          endcase
        end
        // A strobe coinciding with terminal count is still a success.
        ST_CAL: if (cal_done || wd_tc) begin
          resp_q   <= cal_done ? POS_ACK : NEG_ACK;
          in_cal_q <= 1'b0;
          state_q  <= ST_RESP;
        end
        ST_HDG, ST_MV: if (mv_cmplt || wd_tc) begin
          resp_q  <= mv_cmplt ? POS_ACK : NEG_ACK;
          state_q <= ST_RESP;
        end
        ST_SOLVE: if (sol_cmplt) begin
          resp_q   <= POS_ACK;
          cmd_md_q <= 1'b1;
          state_q  <= ST_RESP;
        end
        ST_RESP: begin
          send_resp_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign clr_cmd_rdy = clr_cmd_rdy_q;
  assign send_resp   = send_resp_q;
  assign strt_cal    = strt_cal_q;
  assign strt_hdng   = strt_hdng_q;
  assign strt_mv     = strt_mv_q;
  assign in_cal      = in_cal_q;
  assign stp_lft     = stp_lft_q;
  assign stp_rght    = stp_rght_q;
  assign cmd_md      = cmd_md_q;
  assign resp        = resp_q;
  assign dsrd_hdg    = dsrd_hdg_q;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed bench for cmd_sequencer: each command type, error paths,
// watchdog boundary, pending cmd_rdy and asynchronous reset.
module tb_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cmd = 16'h0000;
  logic        cmd_rdy = 1'b0;
  logic        cal_done = 1'b0;
  logic        mv_cmplt = 1'b0;
  logic        sol_cmplt = 1'b0;
  logic        clr_cmd_rdy, send_resp, strt_cal, in_cal, strt_hdng, strt_mv;
  logic        stp_lft, stp_rght, cmd_md;
  logic [7:0]  resp;
  logic [11:0] dsrd_hdg;

  int n_checks = 0;
  int n_fail = 0;

  localparam int WD_CYC = 1 << 14;

  cmd_sequencer #(.FAST_SIM(1'b1), .POS_ACK(8'hA5), .NEG_ACK(8'h5A)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .send_resp   (send_resp),
    .strt_cal    (strt_cal),
    .cal_done    (cal_done),
    .in_cal      (in_cal),
    .strt_hdng   (strt_hdng),
    .dsrd_hdg    (dsrd_hdg),
    .strt_mv     (strt_mv),
    .stp_lft     (stp_lft),
    .stp_rght    (stp_rght),
    .mv_cmplt    (mv_cmplt),
    .cmd_md      (cmd_md),
    .sol_cmplt   (sol_cmplt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, limit 1000000 ns");
    $fatal(1);
  end

  // Returns the number of negedges until send_resp is seen, or -1.
  task automatic wait_send_resp(input int max, output int cycles);
    cycles = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (send_resp === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({clr_cmd_rdy, send_resp, strt_cal, strt_hdng, strt_mv, in_cal, stp_lft, stp_rght} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_pulses: got %b expected 00000000",
               {clr_cmd_rdy, send_resp, strt_cal, strt_hdng, strt_mv, in_cal, stp_lft, stp_rght});
    end
    n_checks++;
    if ({resp, dsrd_hdg, cmd_md} !== {8'h00, 12'h000, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_regs: resp=%h hdg=%h cmd_md=%b expected 00 000 1", resp, dsrd_hdg, cmd_md);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cal();
    int bad;
    cmd = 16'h0000; cmd_rdy = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({clr_cmd_rdy, strt_cal, in_cal, strt_hdng, strt_mv} !== 5'b11100) begin
      n_fail++;
      $display("FAIL cal_accept: clr,strt_cal,in_cal,strt_hdng,strt_mv=%b expected 11100",
               {clr_cmd_rdy, strt_cal, in_cal, strt_hdng, strt_mv});
    end
    cmd_rdy = 1'b0;
    bad = 0;
    for (int i = 0; i < 499; i++) begin
      @(negedge clk);
      if (strt_cal !== 1'b0 || in_cal !== 1'b1 || send_resp !== 1'b0 || clr_cmd_rdy !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL cal_wait: %0d bad cycles expected 0", bad);
    end
    cal_done = 1'b1;
    @(negedge clk);
    cal_done = 1'b0;
    n_checks++;
    if ({send_resp, in_cal} !== 2'b00) begin
      n_fail++;
      $display("FAIL cal_strobe_edge: send_resp,in_cal=%b expected 00", {send_resp, in_cal});
    end
    @(negedge clk);
    n_checks++;
    if ({send_resp, resp} !== {1'b1, 8'hA5}) begin
      n_fail++;
      $display("FAIL cal_resp: send_resp=%b resp=%h expected 1 a5", send_resp, resp);
    end
    @(negedge clk);
    n_checks++;
    if (send_resp !== 1'b0) begin
      n_fail++;
      $display("FAIL cal_resp_pulse: send_resp=%b expected 0", send_resp);
    end
  endtask

  task automatic test_hdg();
    int bad, cyc;
    cmd = 16'h23FF; cmd_rdy = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({clr_cmd_rdy, strt_hdng, strt_cal, strt_mv, dsrd_hdg} !== {4'b1100, 12'h3FF}) begin
      n_fail++;
      $display("FAIL hdg_accept: clr,hdng,cal,mv=%b hdg=%h expected 1100 3ff",
               {clr_cmd_rdy, strt_hdng, strt_cal, strt_mv}, dsrd_hdg);
    end
    cmd_rdy = 1'b0;
    bad = 0;
    for (int i = 0; i < 999; i++) begin
      @(negedge clk);
      if (strt_hdng !== 1'b0 || send_resp !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL hdg_wait: %0d bad cycles expected 0", bad);
    end
    mv_cmplt = 1'b1;
    @(negedge clk);
    mv_cmplt = 1'b0;
    wait_send_resp(5, cyc);
    n_checks++;
    if (cyc !== 1 || resp !== 8'hA5 || dsrd_hdg !== 12'h3FF) begin
      n_fail++;
      $display("FAIL hdg_resp: latency=%0d resp=%h hdg=%h expected 1 a5 3ff", cyc, resp, dsrd_hdg);
    end
  endtask

  task automatic test_mv_pending();
    int bad, cyc;
    cmd = 16'h4003; cmd_rdy = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({clr_cmd_rdy, strt_mv, stp_lft, stp_rght, strt_hdng} !== 5'b11110) begin
      n_fail++;
      $display("FAIL mv_accept: clr,mv,lft,rght,hdng=%b expected 11110",
               {clr_cmd_rdy, strt_mv, stp_lft, stp_rght, strt_hdng});
    end
    cmd_rdy = 1'b0;
    @(negedge clk);
    cmd = 16'h4001; cmd_rdy = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (clr_cmd_rdy !== 1'b0 || strt_mv !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL mv_pending_held: %0d cycles with clr/strt expected 0", bad);
    end
    mv_cmplt = 1'b1;
    @(negedge clk);
    mv_cmplt = 1'b0;
    n_checks++;
    if ({clr_cmd_rdy, send_resp} !== 2'b00) begin
      n_fail++;
      $display("FAIL mv_pending_resp_state: clr,send=%b expected 00", {clr_cmd_rdy, send_resp});
    end
    @(negedge clk);
    n_checks++;
    if ({clr_cmd_rdy, send_resp, resp} !== {2'b01, 8'hA5}) begin
      n_fail++;
      $display("FAIL mv_resp: clr,send=%b resp=%h expected 01 a5", {clr_cmd_rdy, send_resp}, resp);
    end
    @(negedge clk);
    n_checks++;
    if ({clr_cmd_rdy, strt_mv, stp_lft, stp_rght} !== 4'b1101) begin
      n_fail++;
      $display("FAIL mv_pending_accept: clr,mv,lft,rght=%b expected 1101",
               {clr_cmd_rdy, strt_mv, stp_lft, stp_rght});
    end
    cmd_rdy = 1'b0;
    mv_cmplt = 1'b1;
    @(negedge clk);
    mv_cmplt = 1'b0;
    wait_send_resp(5, cyc);
    n_checks++;
    if (cyc !== 1 || resp !== 8'hA5) begin
      n_fail++;
      $display("FAIL mv2_resp: latency=%0d resp=%h expected 1 a5", cyc, resp);
    end
  endtask

  task automatic test_solve();
    int bad, cyc;
    cmd = 16'h6000; cmd_rdy = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({clr_cmd_rdy, cmd_md, strt_cal, strt_hdng, strt_mv} !== 5'b10000) begin
      n_fail++;
      $display("FAIL solve_accept: clr,cmd_md,cal,hdng,mv=%b expected 10000",
               {clr_cmd_rdy, cmd_md, strt_cal, strt_hdng, strt_mv});
    end
    cmd_rdy = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cal_done = (i == 3);
      mv_cmplt = (i == 7);
      @(negedge clk);
      if (send_resp !== 1'b0 || cmd_md !== 1'b0) bad++;
    end
    cal_done = 1'b0; mv_cmplt = 1'b0;
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL solve_ignore_strobes: %0d bad cycles expected 0", bad);
    end
    sol_cmplt = 1'b1;
    @(negedge clk);
    sol_cmplt = 1'b0;
    n_checks++;
    if ({cmd_md, send_resp} !== 2'b10) begin
      n_fail++;
      $display("FAIL solve_cmd_md: cmd_md,send=%b expected 10", {cmd_md, send_resp});
    end
    wait_send_resp(5, cyc);
    n_checks++;
    if (cyc !== 1 || resp !== 8'hA5 || cmd_md !== 1'b1) begin
      n_fail++;
      $display("FAIL solve_resp: latency=%0d resp=%h cmd_md=%b expected 1 a5 1", cyc, resp, cmd_md);
    end
  endtask

  task automatic test_illegal();
    cmd = 16'hE000; cmd_rdy = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({clr_cmd_rdy, strt_cal, strt_hdng, strt_mv, cmd_md} !== 5'b10001) begin
      n_fail++;
      $display("FAIL illegal_accept: clr,cal,hdng,mv,cmd_md=%b expected 10001",
               {clr_cmd_rdy, strt_cal, strt_hdng, strt_mv, cmd_md});
    end
    cmd_rdy = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({send_resp, resp} !== {1'b1, 8'h5A} || {strt_cal, strt_hdng, strt_mv} !== 3'b000) begin
      n_fail++;
      $display("FAIL illegal_resp: send=%b resp=%h strt=%b expected 1 5a 000",
               send_resp, resp, {strt_cal, strt_hdng, strt_mv});
    end
    @(negedge clk);
  endtask

  task automatic test_wd_tie();
    int cyc;
    cmd = 16'h0000; cmd_rdy = 1'b1;
    @(negedge clk);
    cmd_rdy = 1'b0;
    repeat (WD_CYC - 1) @(negedge clk);
    n_checks++;
    if ({in_cal, send_resp} !== 2'b10) begin
      n_fail++;
      $display("FAIL tie_last_cal_cycle: in_cal,send=%b expected 10", {in_cal, send_resp});
    end
    cal_done = 1'b1;
    @(negedge clk);
    cal_done = 1'b0;
    wait_send_resp(5, cyc);
    n_checks++;
    if (cyc !== 1 || resp !== 8'hA5) begin
      n_fail++;
      $display("FAIL tie_resp: latency=%0d resp=%h expected 1 a5", cyc, resp);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int cyc, bad;
    cmd = 16'h0000; cmd_rdy = 1'b1;
    @(negedge clk);
    cmd_rdy = 1'b0;
    wait_send_resp(WD_CYC + 10, cyc);
    n_checks++;
    if (cyc !== WD_CYC + 1 || resp !== 8'h5A || in_cal !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_resp: latency=%0d resp=%h in_cal=%b expected %0d 5a 0",
               cyc, resp, in_cal, WD_CYC + 1);
    end
    cal_done = 1'b1;
    @(negedge clk);
    cal_done = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (send_resp !== 1'b0 || clr_cmd_rdy !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL late_strobe_ignored: %0d bad cycles expected 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, bad;
    cmd = 16'h2123; cmd_rdy = 1'b1;
    @(negedge clk);
    cmd_rdy = 1'b0;
    n_checks++;
    if (dsrd_hdg !== 12'h123) begin
      n_fail++;
      $display("FAIL rst_mid_hdg_latch: hdg=%h expected 123", dsrd_hdg);
    end
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({clr_cmd_rdy, send_resp, strt_cal, strt_hdng, strt_mv, in_cal, stp_lft, stp_rght} !== 8'h00 ||
        {resp, dsrd_hdg, cmd_md} !== {8'h00, 12'h000, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_mid_async: pulses=%b resp=%h hdg=%h cmd_md=%b expected 00000000 00 000 1",
               {clr_cmd_rdy, send_resp, strt_cal, strt_hdng, strt_mv, in_cal, stp_lft, stp_rght},
               resp, dsrd_hdg, cmd_md);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mv_cmplt = 1'b1;
    @(negedge clk);
    mv_cmplt = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (send_resp !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL rst_mid_no_resp: %0d send_resp cycles expected 0", bad);
    end
    cmd = 16'h0000; cmd_rdy = 1'b1;
    @(negedge clk);
    cmd_rdy = 1'b0;
    n_checks++;
    if ({clr_cmd_rdy, strt_cal, in_cal} !== 3'b111) begin
      n_fail++;
      $display("FAIL rst_mid_cal_accept: clr,strt_cal,in_cal=%b expected 111",
               {clr_cmd_rdy, strt_cal, in_cal});
    end
    repeat (3) @(negedge clk);
    cal_done = 1'b1;
    @(negedge clk);
    cal_done = 1'b0;
    wait_send_resp(5, cyc);
    n_checks++;
    if (cyc !== 1 || resp !== 8'hA5) begin
      n_fail++;
      $display("FAIL rst_mid_cal_resp: latency=%0d resp=%h expected 1 a5", cyc, resp);
    end
  endtask

  initial begin
    test_reset();
    test_cal();
    test_hdg();
    test_mv_pending();
    test_solve();
    test_illegal();
    test_wd_tie();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
